// File: rtl/ucsbece154_icache_pkg.sv
// ucsbece154_icache_pkg
// Shared definitions for the pseudo-LRU instruction cache: controller state
// encoding, address-field width helpers and the per-set PLRU bit count.
// No ports (package).
package ucsbece154_icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REFILL    = 2'd1,
    S_FILL_DONE = 2'd2
  } state_e;

  // Byte offset width: 2 bits of byte-in-word plus the word-in-line select.
  function automatic int offset_bits(input int block_words);
    return 2 + $clog2(block_words);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int num_sets, input int block_words);
    return 32 - offset_bits(block_words) - index_bits(num_sets);
  endfunction

  // A binary tree over N ways has N-1 internal nodes.
  function automatic int plru_bits(input int num_ways);
    return num_ways - 1;
  endfunction

  localparam int DEFAULT_PLRU_BITS = plru_bits(4);

endpackage

// File: rtl/ucsbece154_plru_tree.sv
// ucsbece154_plru_tree
// Tree pseudo-LRU state for one cache set. Node bits are stored in heap order
// (node n has children 2n+1 and 2n+2; leaves are ways). A node bit of 0 means
// the colder side is the left subtree, 1 the right subtree.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (all bits to 0)
//   touch_en_i     update the tree toward touch_way_i this cycle
//   touch_way_i    way that was just used (hit or fill)
//   victim_o       way the tree currently points at (combinational)
module ucsbece154_plru_tree
  import ucsbece154_icache_pkg::*;
#(
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        touch_en_i,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way_i,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

  localparam int WAYW = $clog2(NUM_WAYS);
  localparam int NB   = plru_bits(NUM_WAYS);
  localparam int NN   = 2 * NUM_WAYS - 1;

  logic [NB-1:0] bits_q, bits_d;

  // Follow the bits from the root; the single reached leaf is the victim.
  always_comb begin : victim_walk
    logic [NN-1:0] reach;
    reach    = '0;
    reach[0] = 1'b1;
    for (int n = 0; n < NB; n++) begin
      reach[2*n+1] = reach[n] & ~bits_q[n];
      reach[2*n+2] = reach[n] &  bits_q[n];
    end
    victim_o = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (reach[NB+w]) victim_o = WAYW'(w);
    end
  end

  // Mark which nodes lie above the touched leaf, then point each of them
  // at the sibling subtree (away from the touched way).
  always_comb begin : touch_walk
    logic [NN-1:0] on_path;
    on_path = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      on_path[NB+w] = (touch_way_i == WAYW'(w));
    end
    for (int n = NB - 1; n >= 0; n--) begin
      on_path[n] = on_path[2*n+1] | on_path[2*n+2];
    end
    bits_d = bits_q;
    if (touch_en_i) begin
      for (int n = 0; n < NB; n++) begin
        if (on_path[n]) bits_d[n] = on_path[2*n+1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bits_q <= '0;
    else       bits_q <= bits_d;
  end

endmodule

// File: rtl/ucsbece154_icache_plru.sv
// ucsbece154_icache_plru
// Set-associative instruction cache with tree pseudo-LRU replacement,
// optional early restart and mispredict squash during refill.
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   ReadEnable, ReadAddress         fetch request (ignored while Busy)
//   Mispredict                      squash outstanding fetch / block lookup
//   Instruction, Ready              fetched word with one-cycle valid pulse
//   Busy                            refill in progress
//   MemReadAddress, MemReadRequest  block-aligned refill request to SDRAM
//   MemDataIn, MemDataReady         refill beats, word 0 first
//   HitCount, MissCount             free-running lookup counters
//
// state       | meaning
// S_IDLE      | accept lookups; hit answers next cycle, miss starts refill
// S_REFILL    | collecting beats into the line buffer; may forward early
// S_FILL_DONE | line installed; late Ready if still owed; back to idle
module ucsbece154_icache_plru
  import ucsbece154_icache_pkg::*;
#(
  parameter int NUM_SETS      = 8,
  parameter int NUM_WAYS      = 4,
  parameter int BLOCK_WORDS   = 4,
  parameter int WORD_SIZE     = 32,
  parameter int EARLY_RESTART = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Mispredict,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady,
  output logic [31:0]          HitCount,
  output logic [31:0]          MissCount
);

  localparam int OFFW  = offset_bits(BLOCK_WORDS);
  localparam int IDXW  = index_bits(NUM_SETS);
  localparam int TAGW  = tag_bits(NUM_SETS, BLOCK_WORDS);
  localparam int WORDW = $clog2(BLOCK_WORDS);
  localparam int WAYW  = $clog2(NUM_WAYS);
  localparam int LINES = NUM_SETS * NUM_WAYS;

  // Storage: flat arrays indexed by {set, way} and {set, way, word}.
  logic [TAGW-1:0]      tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES*BLOCK_WORDS];
  logic [WORD_SIZE-1:0] buf_q  [BLOCK_WORDS];
  logic [LINES-1:0]     valid_q;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      set_q, set_d;
  logic [TAGW-1:0]      rtag_q, rtag_d;
  logic [WORDW-1:0]     word_q, word_d;
  logic [WAYW-1:0]      victim_q, victim_d;
  logic [WORDW-1:0]     beat_q, beat_d;
  logic                 early_q, early_d;
  logic                 delivered_q, delivered_d;
  logic                 squash_q, squash_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic                 ready_q, ready_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic [31:0]          mem_addr_q, mem_addr_d;

  logic [WORDW-1:0] req_word;
  logic [IDXW-1:0]  req_set;
  logic [TAGW-1:0]  req_tag;
  logic             hit;
  logic [WAYW-1:0]  hit_way;
  logic             inv_found;
  logic [WAYW-1:0]  inv_way;
  logic [WAYW-1:0]  victim_sel;
  logic [WAYW-1:0]  tree_victim [NUM_SETS];
  logic             touch_en;
  logic [IDXW-1:0]  touch_set;
  logic [WAYW-1:0]  touch_way;
  logic             fill_we;
  logic             squash_now;
  logic             unused_addr_lsbs;

  assign req_word = ReadAddress[OFFW-1:2];
  assign req_set  = ReadAddress[OFFW+IDXW-1:OFFW];
  assign req_tag  = ReadAddress[31:OFFW+IDXW];
  // Instruction fetches are word aligned; byte bits carry no information.
  assign unused_addr_lsbs = ^ReadAddress[1:0];

  // Parallel tag compare plus lowest-index invalid way of the addressed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[{req_set, WAYW'(w)}] && (tag_q[{req_set, WAYW'(w)}] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[{req_set, WAYW'(w)}]) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
  end

  assign victim_sel = inv_found ? inv_way : tree_victim[req_set];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_plru
    ucsbece154_plru_tree #(
      .NUM_WAYS (NUM_WAYS)
    ) u_tree (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .touch_en_i  (touch_en && (touch_set == IDXW'(s))),
      .touch_way_i (touch_way),
      .victim_o    (tree_victim[s])
    );
  end

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    rtag_d      = rtag_q;
    word_d      = word_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    early_d     = early_q;
    delivered_d = delivered_q;
    squash_d    = squash_q;
    instr_d     = instr_q;
    ready_d     = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_addr_d  = mem_addr_q;
    touch_en    = 1'b0;
    touch_set   = req_set;
    touch_way   = hit_way;
    fill_we     = 1'b0;
    // A mispredict in the very cycle a word would be handed over also kills it.
    squash_now  = squash_q | Mispredict;

    case (state_q)
      S_IDLE: begin
        if (ReadEnable && !Mispredict) begin
          if (hit) begin
            ready_d   = 1'b1;
            instr_d   = data_q[{req_set, hit_way, req_word}];
            touch_en  = 1'b1;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            miss_cnt_d  = miss_cnt_q + 32'd1;
            set_d       = req_set;
            rtag_d      = req_tag;
            word_d      = req_word;
            victim_d    = victim_sel;
            beat_d      = '0;
            early_d     = 1'b0;
            delivered_d = 1'b0;
            squash_d    = 1'b0;
            mem_addr_d  = {ReadAddress[31:OFFW], {OFFW{1'b0}}};
            state_d     = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        if (Mispredict) squash_d = 1'b1;
        // Requested beat landed in the buffer last cycle: forward it now.
        if (early_q && !delivered_q && !squash_now) begin
          ready_d     = 1'b1;
          instr_d     = buf_q[word_q];
          delivered_d = 1'b1;
        end
        if (MemDataReady) begin
          beat_d = beat_q + 1'b1;
          if ((EARLY_RESTART != 0) && (beat_q == word_q)) early_d = 1'b1;
          if (beat_q == WORDW'(BLOCK_WORDS - 1)) begin
            fill_we   = 1'b1;
            touch_en  = 1'b1;
            touch_set = set_q;
            touch_way = victim_q;
            state_d   = S_FILL_DONE;
          end
        end
      end

      S_FILL_DONE: begin
        if (!delivered_q && !squash_now) begin
          ready_d     = 1'b1;
          instr_d     = buf_q[word_q];
          delivered_d = 1'b1;
        end
        squash_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      set_q       <= '0;
      rtag_q      <= '0;
      word_q      <= '0;
      victim_q    <= '0;
      beat_q      <= '0;
      early_q     <= 1'b0;
      delivered_q <= 1'b0;
      squash_q    <= 1'b0;
      instr_q     <= '0;
      ready_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      mem_addr_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      rtag_q      <= rtag_d;
      word_q      <= word_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      early_q     <= early_d;
      delivered_q <= delivered_d;
      squash_q    <= squash_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mem_addr_q  <= mem_addr_d;
      if (fill_we) valid_q[{set_q, victim_q}] <= 1'b1;
    end
  end

  // Array and beat-buffer writes; the last beat goes straight into the line
  // since it is not yet in the buffer when the line is written.
  always_ff @(posedge Clk) begin
    if ((state_q == S_REFILL) && MemDataReady) buf_q[beat_q] <= WORD_SIZE'(MemDataIn);
    if (fill_we) begin
      tag_q[{set_q, victim_q}] <= rtag_q;
      for (int b = 0; b < BLOCK_WORDS; b++) begin
        data_q[{set_q, victim_q, WORDW'(b)}] <=
          (WORDW'(b) == beat_q) ? WORD_SIZE'(MemDataIn) : buf_q[b];
      end
    end
  end

  assign Instruction    = instr_q;
  assign Ready          = ready_q;
  assign Busy           = (state_q != S_IDLE);
  assign MemReadRequest = (state_q != S_IDLE);
  assign MemReadAddress = mem_addr_q;
  assign HitCount       = hit_cnt_q;
  assign MissCount      = miss_cnt_q;

endmodule

// File: tb/tb_ucsbece154_icache_plru.sv
// Directed bench for ucsbece154_icache_plru (default geometry, early restart on).
// Stimulus pushes expected {word, cycle} for every Ready it is owed; a monitor
// on the falling edge pops and compares each Ready pulse.
module tb_ucsbece154_icache_plru;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReadEnable;
  logic [31:0] ReadAddress;
  logic        Mispredict;
  logic [31:0] Instruction;
  logic        Ready;
  logic        Busy;
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn;
  logic        MemDataReady;
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  ucsbece154_icache_plru dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ReadEnable     (ReadEnable),
    .ReadAddress    (ReadAddress),
    .Mispredict     (Mispredict),
    .Instruction    (Instruction),
    .Ready          (Ready),
    .Busy           (Busy),
    .MemReadAddress (MemReadAddress),
    .MemReadRequest (MemReadRequest),
    .MemDataIn      (MemDataIn),
    .MemDataReady   (MemDataReady),
    .HitCount       (HitCount),
    .MissCount      (MissCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  int   hits   = 0;
  int   misses = 0;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Ready monitor / scoreboard.
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (!Reset && Ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL ready_unexpected cyc=%0d got=%h want=no_ready", cyc, Instruction);
      end else begin
        e = q.pop_front();
        if (Instruction !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL ready_word got=%h@%0d want=%h@%0d", Instruction, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic expect_ready(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // One fetch. base is the data of beat 0 of the block (beat i = base+i).
  // mp_beat >= 0 raises Mispredict alongside that beat.
  task automatic read_req(input logic [31:0] addr, input bit exp_hit,
                          input logic [31:0] base, input int mp_beat);
    int w;
    bit squashed;
    w = int'(addr[3:2]);
    squashed = 1'b0;
    ReadEnable  = 1'b1;
    ReadAddress = addr;
    tick();
    ReadEnable = 1'b0;
    if (exp_hit) begin
      hits++;
      expect_ready(base + w, cyc);
      chk("hit_busy", {31'd0, Busy}, 32'd0);
    end else begin
      misses++;
      chk("miss_req", {31'd0, MemReadRequest}, 32'd1);
      chk("miss_addr", MemReadAddress, {addr[31:4], 4'h0});
      for (int b = 0; b < 4; b++) begin
        MemDataReady = 1'b1;
        MemDataIn    = base + b;
        Mispredict   = (b == mp_beat);
        tick();
        if (Mispredict) squashed = 1'b1;
        if (b == w && !squashed) expect_ready(base + b, cyc + 1);
      end
      MemDataReady = 1'b0;
      Mispredict   = 1'b0;
      MemDataIn    = 32'd0;
      chk("filldone_busy", {31'd0, Busy}, 32'd1);
      tick();
      chk("done_busy", {31'd0, Busy}, 32'd0);
      chk("done_req", {31'd0, MemReadRequest}, 32'd0);
    end
  endtask

  initial begin
    Reset        = 1'b1;
    ReadEnable   = 1'b0;
    ReadAddress  = 32'd0;
    Mispredict   = 1'b0;
    MemDataIn    = 32'd0;
    MemDataReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();

    chk("rst_instr", Instruction, 32'd0);
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_req", {31'd0, MemReadRequest}, 32'd0);
    chk("rst_maddr", MemReadAddress, 32'd0);
    chk("rst_hits", HitCount, 32'd0);
    chk("rst_misses", MissCount, 32'd0);

    // Cold miss (word 0 forwarded one cycle after beat 0), then a hit.
    read_req(32'h0001_0000, 1'b0, 32'hA0, -1);
    read_req(32'h0001_0000, 1'b1, 32'hA0, -1);
    chk("cnt_hit1", HitCount, 32'd1);
    chk("cnt_miss1", MissCount, 32'd1);

    // Requested word is the last beat: single Ready one cycle after it.
    read_req(32'h0002_000C, 1'b0, 32'hB0, -1);
    read_req(32'h0002_0004, 1'b1, 32'hB0, -1);

    // PLRU in set 0: keep way 0 (A) hot; fifth tag E must evict C (way 2).
    read_req(32'h0001_0008, 1'b1, 32'hA0, -1);
    read_req(32'h0003_0000, 1'b0, 32'hC0, -1);
    read_req(32'h0001_0004, 1'b1, 32'hA0, -1);
    read_req(32'h0004_0000, 1'b0, 32'hD0, -1);
    read_req(32'h0001_0000, 1'b1, 32'hA0, -1);
    read_req(32'h0005_0000, 1'b0, 32'hE0, -1);
    read_req(32'h0001_000C, 1'b1, 32'hA0, -1);
    read_req(32'h0002_0000, 1'b1, 32'hB0, -1);
    read_req(32'h0004_0004, 1'b1, 32'hD0, -1);
    read_req(32'h0005_0008, 1'b1, 32'hE0, -1);
    read_req(32'h0003_0004, 1'b0, 32'hC0, -1);

    // Mispredict during beat 2 (requested word 2): no Ready, line installed.
    read_req(32'h0000_0018, 1'b0, 32'hF0, 2);
    read_req(32'h0000_0018, 1'b1, 32'hF0, -1);
    read_req(32'h0000_0010, 1'b1, 32'hF0, -1);

    // ReadEnable with Mispredict in idle: no lookup at all.
    ReadEnable  = 1'b1;
    Mispredict  = 1'b1;
    ReadAddress = 32'h0006_0000;
    tick();
    ReadEnable = 1'b0;
    Mispredict = 1'b0;
    chk("mp_idle_req", {31'd0, MemReadRequest}, 32'd0);
    chk("mp_idle_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("cnt_hits", HitCount, hits);
    chk("cnt_misses", MissCount, misses);

    // Asynchronous reset in the middle of a refill.
    ReadEnable  = 1'b1;
    ReadAddress = 32'h0007_002C;
    tick();
    ReadEnable   = 1'b0;
    MemDataReady = 1'b1;
    MemDataIn    = 32'h70;
    tick();
    MemDataReady = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_req", {31'd0, MemReadRequest}, 32'd0);
    chk("arst_maddr", MemReadAddress, 32'd0);
    chk("arst_ready", {31'd0, Ready}, 32'd0);
    chk("arst_instr", Instruction, 32'd0);
    chk("arst_hits", HitCount, 32'd0);
    chk("arst_misses", MissCount, 32'd0);
    tick();
    Reset  = 1'b0;
    hits   = 0;
    misses = 0;
    tick();
    read_req(32'h0001_0000, 1'b0, 32'hA0, -1);
    read_req(32'h0007_002C, 1'b0, 32'h70, -1);
    read_req(32'h0001_0004, 1'b1, 32'hA0, -1);
    chk("post_rst_hits", HitCount, 32'd1);
    chk("post_rst_misses", MissCount, 32'd2);

    tick();
    tick();
    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL ready_missing got=%0d_pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
